// File: rtl/ram_word_reader_pkg.sv
// rtl/ram_word_reader_pkg.sv - shared RAM geometry and reader FSM state encoding
package ram_word_reader_pkg;

   localparam int RAM_ADDR_W     = 6;
   localparam int RAM_DATA_W     = 32;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_SEND  = 3'd3,
      ST_FIN   = 3'd4
   } state_t;

endpackage

// File: rtl/word_byte_serializer.sv
// rtl/word_byte_serializer.sv - splits one RAM word into bytes, MSB first, on a valid/ready port
module word_byte_serializer
   import ram_word_reader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [31:0] word_i,
   output logic [7:0]  byte_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        last_o
);

   logic [31:0] word_q, word_d;
   logic [1:0]  idx_q, idx_d;
   logic        valid_q, valid_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         word_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         word_q  <= word_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

   // The word is held unchanged; idx selects the byte, so a stalled byte stays stable.
   always_comb begin
      word_d  = word_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      if (load_i) begin
         word_d  = word_i;
         idx_d   = 2'(BYTES_PER_WORD - 1);
         valid_d = 1'b1;
      end else if (valid_q && ready_i) begin
         if (idx_q != 2'd0) begin
            idx_d = idx_q - 2'd1;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   assign byte_o  = word_q[{idx_q, 3'b000} +: 8];
   assign valid_o = valid_q;
   assign last_o  = valid_q && (idx_q == 2'd0);

endmodule

// File: rtl/ram_word_reader.sv
// rtl/ram_word_reader.sv - streams Word_Count RAM words from Start_Addr as bytes, MSB first
module ram_word_reader
   import ram_word_reader_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Start,
   input  logic [ADDR_W-1:0] Start_Addr,
   input  logic [ADDR_W:0]   Word_Count,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic              Mem_Read,
   output logic              Mem_Write,
   input  logic [DATA_W-1:0] Mem_R_Data,
   output logic [7:0]        Byte_Out,
   output logic              Byte_Valid,
   input  logic              Byte_Ready,
   output logic              Busy,
   output logic              Done
);

   localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   remaining_q, remaining_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              load;
   logic              last_byte;
   logic [ADDR_W:0]   count_clamped;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign count_clamped = (Word_Count > MAX_WORDS) ? MAX_WORDS : Word_Count;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      load        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               addr_d      = Start_Addr;
               remaining_d = count_clamped;
               busy_d      = 1'b1;
               state_d     = (Word_Count == '0) ? ST_FIN : ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            load    = 1'b1;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            // Address and word count advance only once the whole word has been accepted.
            if (last_byte && Byte_Ready) begin
               remaining_d = remaining_q - ONE_WORD;
               addr_d      = addr_q + 1'b1;
               state_d     = (remaining_q != ONE_WORD) ? ST_ISSUE : ST_FIN;
            end
         end
         ST_FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   word_byte_serializer u_serializer (
      .clk_i   (Clk),
      .rst_i   (Rst),
      .load_i  (load),
      .word_i  (Mem_R_Data[31:0]),
      .byte_o  (Byte_Out),
      .valid_o (Byte_Valid),
      .ready_i (Byte_Ready),
      .last_o  (last_byte)
   );

   assign Mem_Addr  = addr_q;
   assign Mem_Read  = (state_q == ST_ISSUE);
   assign Mem_Write = 1'b0;
   assign Busy      = busy_q;
   assign Done      = done_q;

endmodule

// File: tb/tb_ram_word_reader.sv
// tb/tb_ram_word_reader.sv - directed vector bench for ram_word_reader with a registered-read RAM model
module tb_ram_word_reader;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Start;
   logic [5:0]  Start_Addr;
   logic [6:0]  Word_Count;
   logic [5:0]  Mem_Addr;
   logic        Mem_Read;
   logic        Mem_Write;
   logic [31:0] Mem_R_Data;
   logic [7:0]  Byte_Out;
   logic        Byte_Valid;
   logic        Byte_Ready;
   logic        Busy;
   logic        Done;

   int tests = 0;
   int fails = 0;

   logic [31:0] ram [64];
   logic [7:0]  got [$];
   logic [5:0]  addrs [$];
   int          reads;
   int          dones;
   logic        prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b1;
   logic [7:0]  prev_b = '0;

   typedef struct {
      logic [5:0]  addr;
      logic [6:0]  cnt;
      logic        stall;
      logic [7:0]  stall_byte;
      int          inject;
      int          nbytes;
      logic [63:0] exp;
      int          exp_reads;
      int          exp_done;
      logic [5:0]  exp_a0;
      logic [5:0]  exp_a1;
   } vec_t;

   vec_t vecs [7];

   always #5 Clk = ~Clk;

   ram_word_reader dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .Start      (Start),
      .Start_Addr (Start_Addr),
      .Word_Count (Word_Count),
      .Mem_Addr   (Mem_Addr),
      .Mem_Read   (Mem_Read),
      .Mem_Write  (Mem_Write),
      .Mem_R_Data (Mem_R_Data),
      .Byte_Out   (Byte_Out),
      .Byte_Valid (Byte_Valid),
      .Byte_Ready (Byte_Ready),
      .Busy       (Busy),
      .Done       (Done)
   );

   always @(posedge Clk) begin
      if (Mem_Read) Mem_R_Data <= ram[Mem_Addr];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard capture plus stall-stability check, sampled on the falling edge.
   always @(negedge Clk) begin
      if (!Rst) begin
         if (Byte_Valid && Byte_Ready) got.push_back(Byte_Out);
         if (Mem_Read) begin
            reads++;
            addrs.push_back(Mem_Addr);
         end
         if (Done) dones++;
         if (prev_v && !prev_r && !prev_rst)
            check("stall_hold", {Byte_Valid, Byte_Out}, {1'b1, prev_b});
      end
      prev_v   = Byte_Valid;
      prev_r   = Byte_Ready;
      prev_b   = Byte_Out;
      prev_rst = Rst;
   end

   task automatic run_xfer(input logic [5:0] a, input logic [6:0] c, input logic do_stall,
                           input logic [7:0] sb, input int inject, input int budget,
                           output int done_cyc, output int first_v, output logic busy1);
      int   n;
      int   stall_left;
      logic stalled;
      got.delete();
      addrs.delete();
      reads = 0;
      dones = 0;
      done_cyc = -1;
      first_v = -1;
      busy1 = 1'b0;
      stall_left = 0;
      stalled = 1'b0;
      n = 0;
      @(posedge Clk); #1;
      Start = 1'b1;
      Start_Addr = a;
      Word_Count = c;
      Byte_Ready = 1'b1;
      while (done_cyc < 0 && n < budget) begin
         @(posedge Clk); #1;
         n++;
         Start = (n == inject);
         if (n == inject) begin
            Start_Addr = 6'd5;
            Word_Count = 7'd3;
         end
         if (n == 1) busy1 = Busy;
         if (Byte_Valid && first_v < 0) first_v = n;
         if (do_stall && !stalled && Byte_Valid && Byte_Out == sb) begin
            stall_left = 5;
            stalled = 1'b1;
         end
         if (stall_left > 0) begin
            Byte_Ready = 1'b0;
            stall_left--;
         end else begin
            Byte_Ready = 1'b1;
         end
         if (Done) done_cyc = n;
      end
      Start = 1'b0;
      Byte_Ready = 1'b1;
      if (done_cyc < 0) begin
         tests++;
         fails++;
         $display("FAIL done_timeout: no Done within %0d cycles", budget);
      end
      repeat (6) @(posedge Clk);
      #1;
   endtask

   task automatic apply_vec(input int idx, input vec_t v);
      int   dc, fv;
      logic b1;
      run_xfer(v.addr, v.cnt, v.stall, v.stall_byte, v.inject, 200, dc, fv, b1);
      check($sformatf("v%0d_nbytes", idx), got.size(), v.nbytes);
      for (int i = 0; i < v.nbytes && i < got.size(); i++)
         check($sformatf("v%0d_byte%0d", idx, i), got[i], v.exp[63 - 8*i -: 8]);
      check($sformatf("v%0d_reads", idx), reads, v.exp_reads);
      if (v.exp_reads > 0 && addrs.size() > 0) check($sformatf("v%0d_addr0", idx), addrs[0], v.exp_a0);
      if (v.exp_reads > 1 && addrs.size() > 1) check($sformatf("v%0d_addr1", idx), addrs[1], v.exp_a1);
      check($sformatf("v%0d_done_cycle", idx), dc, v.exp_done);
      check($sformatf("v%0d_done_pulses", idx), dones, 1);
      check($sformatf("v%0d_busy_after_start", idx), b1, 1'b1);
      check($sformatf("v%0d_busy_idle", idx), Busy, 1'b0);
      if (v.nbytes > 0) check($sformatf("v%0d_first_valid", idx), fv, 3);
   endtask

   initial begin
      int   dc, fv, err, dones_before;
      logic b1;

      vecs[0] = '{addr:6'd32, cnt:7'd1, stall:1'b0, stall_byte:8'h00, inject:0, nbytes:4,
                  exp:64'h12345678_00000000, exp_reads:1, exp_done:8, exp_a0:6'd32, exp_a1:6'd0};
      vecs[1] = '{addr:6'd32, cnt:7'd1, stall:1'b1, stall_byte:8'h34, inject:0, nbytes:4,
                  exp:64'h12345678_00000000, exp_reads:1, exp_done:13, exp_a0:6'd32, exp_a1:6'd0};
      vecs[2] = '{addr:6'd63, cnt:7'd2, stall:1'b0, stall_byte:8'h00, inject:0, nbytes:8,
                  exp:64'hAABBCCDD_01020304, exp_reads:2, exp_done:14, exp_a0:6'd63, exp_a1:6'd0};
      vecs[3] = '{addr:6'd5, cnt:7'd0, stall:1'b0, stall_byte:8'h00, inject:0, nbytes:0,
                  exp:64'h0, exp_reads:0, exp_done:2, exp_a0:6'd0, exp_a1:6'd0};
      vecs[4] = '{addr:6'd63, cnt:7'd2, stall:1'b0, stall_byte:8'h00, inject:5, nbytes:8,
                  exp:64'hAABBCCDD_01020304, exp_reads:2, exp_done:14, exp_a0:6'd63, exp_a1:6'd0};
      vecs[5] = '{addr:6'd63, cnt:7'd2, stall:1'b0, stall_byte:8'h00, inject:13, nbytes:8,
                  exp:64'hAABBCCDD_01020304, exp_reads:2, exp_done:14, exp_a0:6'd63, exp_a1:6'd0};
      vecs[6] = '{addr:6'd0, cnt:7'd1, stall:1'b0, stall_byte:8'h00, inject:0, nbytes:4,
                  exp:64'h01020304_00000000, exp_reads:1, exp_done:8, exp_a0:6'd0, exp_a1:6'd0};

      for (int i = 0; i < 64; i++) ram[i] = 32'hDEAD0000 | i;
      ram[32] = 32'h12345678;
      ram[63] = 32'hAABBCCDD;
      ram[0]  = 32'h01020304;

      Rst = 1'b1;
      Start = 1'b0;
      Start_Addr = '0;
      Word_Count = '0;
      Byte_Ready = 1'b0;
      Mem_R_Data = '0;
      repeat (3) @(posedge Clk);
      #1;
      Rst = 1'b0;
      check("reset_mem_addr", Mem_Addr, 6'd0);
      check("reset_mem_read", Mem_Read, 1'b0);
      check("reset_mem_write", Mem_Write, 1'b0);
      check("reset_byte_out", Byte_Out, 8'd0);
      check("reset_byte_valid", Byte_Valid, 1'b0);
      check("reset_busy", Busy, 1'b0);
      check("reset_done", Done, 1'b0);

      for (int i = 0; i < 7; i++) apply_vec(i, vecs[i]);

      for (int i = 0; i < 64; i++) ram[i] = i;

      run_xfer(6'd0, 7'd64, 1'b0, 8'h00, 0, 1000, dc, fv, b1);
      check("sweep_nbytes", got.size(), 256);
      check("sweep_reads", reads, 64);
      check("sweep_done_cycle", dc, 386);
      err = 0;
      for (int j = 0; j < 256 && j < got.size(); j++)
         if (got[j] !== ((j % 4 == 3) ? 8'(j / 4) : 8'h00)) err++;
      check("sweep_byte_errors", err, 0);

      run_xfer(6'd10, 7'd100, 1'b0, 8'h00, 0, 1000, dc, fv, b1);
      check("clamp_nbytes", got.size(), 256);
      check("clamp_reads", reads, 64);
      err = 0;
      for (int j = 0; j < 256 && j < got.size(); j++)
         if (got[j] !== ((j % 4 == 3) ? 8'((10 + j / 4) % 64) : 8'h00)) err++;
      check("clamp_byte_errors", err, 0);
      if (addrs.size() == 64) check("clamp_last_addr", addrs[63], 6'd9);

      // Reset abort while the second of four words is being sent.
      dones = 0;
      @(posedge Clk); #1;
      Start = 1'b1;
      Start_Addr = 6'd10;
      Word_Count = 7'd4;
      Byte_Ready = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         @(posedge Clk); #1;
         Start = 1'b0;
         if (n == 9) check("abort_word2_valid", {Byte_Valid, Byte_Out}, {1'b1, 8'h00});
      end
      Rst = 1'b1;
      @(posedge Clk); #1;
      check("abort_mem_addr", Mem_Addr, 6'd0);
      check("abort_mem_read", Mem_Read, 1'b0);
      check("abort_byte_out", Byte_Out, 8'd0);
      check("abort_byte_valid", Byte_Valid, 1'b0);
      check("abort_busy", Busy, 1'b0);
      check("abort_done", Done, 1'b0);
      Rst = 1'b0;
      dones_before = dones;
      repeat (8) @(posedge Clk);
      #1;
      check("abort_no_done", dones, dones_before);
      check("abort_idle_busy", Busy, 1'b0);

      ram[32] = 32'h12345678;
      apply_vec(7, vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
